// File: rtl/wb_stage.sv
// Writeback stage: arbitrates ALU results against a buffered LSU return FIFO and
// issues one registered register-file write per cycle. Optional macro: WB_FORWARD_EN.
module wb_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned LSU_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  input  logic [2:0]      lsu_funct3,
  input  logic [1:0]      lsu_addr_lo,
  output logic            wb_en,
  output logic [4:0]      wb_wa,
  output logic [XLEN-1:0] wb_data,
  output logic [31:0]     wb_count,
  output logic            lsu_overflow
`ifdef WB_FORWARD_EN
  ,
  input  logic [4:0]      fwd_rs_a,
  input  logic [4:0]      fwd_rs_b,
  output logic            fwd_hit_a,
  output logic            fwd_hit_b,
  output logic [XLEN-1:0] fwd_data_a,
  output logic [XLEN-1:0] fwd_data_b
`endif
);

  typedef enum logic {GRANT_ALU = 1'b0, GRANT_LSU = 1'b1} grant_e;

  typedef struct packed {
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [1:0]      addr_lo;
    logic [XLEN-1:0] data;
  } lsu_entry_t;

  localparam int unsigned  PW       = $clog2(LSU_DEPTH);
  localparam int unsigned  CW       = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(LSU_DEPTH);
  localparam logic [CW-1:0] HI_CNT   = CW'(LSU_DEPTH - 1);

  lsu_entry_t      fifo_mem [LSU_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  grant_e          last_grant_q, last_grant_d;
  logic            ovf_q, ovf_d;
  logic            wb_en_q, wb_en_d;
  logic [4:0]      wb_wa_q, wb_wa_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [31:0]     cnt_q, cnt_d;

  lsu_entry_t      head;
  lsu_entry_t      push_entry;
  logic            fifo_empty, fifo_full;
  logic            lsu_win, alu_win, grant, do_push, do_write;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_fmt, win_data;
  logic [4:0]      win_rd;

  always_comb begin
    head       = fifo_mem[rd_ptr_q];
    push_entry = '{rd: lsu_rd, funct3: lsu_funct3, addr_lo: lsu_addr_lo, data: lsu_data};
  end

  // Arbitration: a nearly-full FIFO always wins, otherwise round-robin on contention.
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL_CNT);
    if (count_q >= HI_CNT) begin
      lsu_win = 1'b1;
    end else if (!fifo_empty && alu_valid) begin
      lsu_win = (last_grant_q == GRANT_ALU);
    end else begin
      lsu_win = !fifo_empty;
    end
    alu_win   = alu_valid & ~lsu_win;
    grant     = lsu_win | alu_win;
    alu_ready = reset & ~lsu_win;
  end

  always_comb begin
    case (head.addr_lo)
      2'd0:    ld_byte = head.data[7:0];
      2'd1:    ld_byte = head.data[15:8];
      2'd2:    ld_byte = head.data[23:16];
      default: ld_byte = head.data[31:24];
    endcase
    ld_half = head.addr_lo[1] ? head.data[31:16] : head.data[15:0];
    case (head.funct3)
      3'b000:  ld_fmt = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_fmt = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_fmt = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_fmt = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_fmt = head.data;
    endcase
  end

  always_comb begin
    win_rd   = lsu_win ? head.rd : alu_rd;
    win_data = lsu_win ? ld_fmt  : alu_data;

    last_grant_d = last_grant_q;
    if (lsu_win) begin
      last_grant_d = GRANT_LSU;
    end else if (alu_win) begin
      last_grant_d = GRANT_ALU;
    end

    // When full, a push is only taken if the head is popped in the same cycle.
    do_push  = lsu_valid & (~fifo_full | lsu_win);
    ovf_d    = ovf_q | (lsu_valid & fifo_full & ~lsu_win);
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = lsu_win ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(lsu_win);

    do_write  = grant & (win_rd != '0);
    wb_en_d   = do_write;
    wb_wa_d   = do_write ? win_rd : '0;
    wb_data_d = do_write ? win_data : '0;
    cnt_d     = cnt_q + 32'(grant);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= GRANT_ALU;
      ovf_q        <= 1'b0;
      wb_en_q      <= 1'b0;
      wb_wa_q      <= '0;
      wb_data_q    <= '0;
      cnt_q        <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      ovf_q        <= ovf_d;
      wb_en_q      <= wb_en_d;
      wb_wa_q      <= wb_wa_d;
      wb_data_q    <= wb_data_d;
      cnt_q        <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_mem[wr_ptr_q] <= push_entry;
    end
  end

  assign wb_en        = wb_en_q;
  assign wb_wa        = wb_wa_q;
  assign wb_data      = wb_data_q;
  assign wb_count     = cnt_q;
  assign lsu_overflow = ovf_q;

`ifdef WB_FORWARD_EN
  always_comb begin
    fwd_hit_a  = wb_en_q && (wb_wa_q == fwd_rs_a) && (fwd_rs_a != '0);
    fwd_hit_b  = wb_en_q && (wb_wa_q == fwd_rs_b) && (fwd_rs_b != '0);
    fwd_data_a = wb_data_q;
    fwd_data_b = wb_data_q;
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Randomized bench for wb_stage against a queue-based reference model, plus
// directed literal checks for extension, contention, x0 and async reset.
module tb_wb_stage;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic [2:0]  lsu_funct3;
  logic [1:0]  lsu_addr_lo;
  logic        wb_en;
  logic [4:0]  wb_wa;
  logic [31:0] wb_data;
  logic [31:0] wb_count;
  logic        lsu_overflow;
`ifdef WB_FORWARD_EN
  logic [4:0]  fwd_rs_a, fwd_rs_b;
  logic        fwd_hit_a, fwd_hit_b;
  logic [31:0] fwd_data_a, fwd_data_b;
`endif

  wb_stage #(.XLEN(32), .LSU_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .lsu_funct3(lsu_funct3), .lsu_addr_lo(lsu_addr_lo),
    .wb_en(wb_en), .wb_wa(wb_wa), .wb_data(wb_data),
    .wb_count(wb_count), .lsu_overflow(lsu_overflow)
`ifdef WB_FORWARD_EN
    , .fwd_rs_a(fwd_rs_a), .fwd_rs_b(fwd_rs_b),
    .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
    .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  bit          last_alu;
  logic        m_en, m_ovf;
  logic [4:0]  m_wa;
  logic [31:0] m_data, m_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fmt(logic [31:0] w, logic [2:0] f3, logic [1:0] lo);
    logic [31:0] b, h;
    b = (w >> (32'(lo) * 8)) & 32'hFF;
    h = (w >> (32'(lo[1]) * 16)) & 32'hFFFF;
    case (f3)
      3'b000:  return (b ^ 32'h80) - 32'h80;
      3'b001:  return (h ^ 32'h8000) - 32'h8000;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic bit pred_lsu();
    int n = q.size();
    if (n == 0) return 1'b0;
    if (n >= int'(DEPTH) - 1) return 1'b1;
    if (alu_valid) return last_alu;
    return 1'b1;
  endfunction

  task automatic model_reset();
    q.delete();
    last_alu = 1'b1;
    m_en = 1'b0; m_wa = '0; m_data = '0; m_count = '0; m_ovf = 1'b0;
  endtask

  task automatic model_step();
    bit lw, g;
    logic [4:0]  rd;
    logic [31:0] d;
    ent_t e;
    lw = pred_lsu();
    g  = lw || alu_valid;
    rd = '0;
    d  = '0;
    if (lw) begin
      e = q.pop_front();
      rd = e.rd;
      d  = fmt(e.data, e.f3, e.lo);
      last_alu = 1'b0;
    end else if (alu_valid) begin
      rd = alu_rd;
      d  = alu_data;
      last_alu = 1'b1;
    end
    if (g) m_count = m_count + 1;
    m_en   = g && (rd != 0);
    m_wa   = m_en ? rd : '0;
    m_data = m_en ? d : '0;
    if (lsu_valid) begin
      if (q.size() < int'(DEPTH)) q.push_back('{rd: lsu_rd, f3: lsu_funct3, lo: lsu_addr_lo, data: lsu_data});
      else m_ovf = 1'b1;
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    #1;
    chk("alu_ready", {31'b0, alu_ready}, {31'b0, reset ? !pred_lsu() : 1'b0});
`ifdef WB_FORWARD_EN
    chk("fwd_hit_a", {31'b0, fwd_hit_a}, {31'b0, m_en && (m_wa == fwd_rs_a) && (fwd_rs_a != 0)});
    chk("fwd_hit_b", {31'b0, fwd_hit_b}, {31'b0, m_en && (m_wa == fwd_rs_b) && (fwd_rs_b != 0)});
    chk("fwd_data_a", fwd_data_a, m_data);
`endif
    @(posedge clk);
    if (reset) model_step();
    @(negedge clk);
    chk("wb_en", {31'b0, wb_en}, {31'b0, m_en});
    chk("wb_wa", {27'b0, wb_wa}, {27'b0, m_wa});
    chk("wb_data", wb_data, m_data);
    chk("wb_count", wb_count, m_count);
    chk("lsu_overflow", {31'b0, lsu_overflow}, {31'b0, m_ovf});
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    lsu_valid = 0; lsu_rd = '0; lsu_data = '0; lsu_funct3 = '0; lsu_addr_lo = '0;
`ifdef WB_FORWARD_EN
    fwd_rs_a = '0; fwd_rs_b = '0;
`endif
  endtask

  task automatic rand_inputs();
    logic [2:0] f3s [7];
    f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110};
    alu_valid   = ($urandom_range(0, 9) < 6);
    alu_rd      = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
    alu_data    = $urandom;
    lsu_valid   = ($urandom_range(0, 9) < 4);
    lsu_rd      = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
    lsu_data    = $urandom;
    lsu_funct3  = f3s[$urandom_range(0, 6)];
    lsu_addr_lo = 2'($urandom);
`ifdef WB_FORWARD_EN
    fwd_rs_a = $urandom_range(0, 1) ? m_wa : 5'($urandom);
    fwd_rs_b = 5'($urandom);
`endif
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Async reset asserted between edges while traffic is flowing.
  task automatic mid_reset();
    rand_inputs();
    alu_valid = 1'b1;
    lsu_valid = 1'b1;
    @(posedge clk);
    model_step();
    #2 reset = 1'b0;
    model_reset();
    #1;
    chk("rst_wb_en", {31'b0, wb_en}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_count", wb_count, 32'd0);
    chk("rst_alu_ready", {31'b0, alu_ready}, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 2; i++) cycle();
    idle();
    reset = 1'b1;
    cycle();
    chk("post_rst_no_stale", {31'b0, wb_en}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    idle();
    model_reset();
    #2;
    chk("reset_wb_en", {31'b0, wb_en}, 32'd0);
    chk("reset_wb_wa", {27'b0, wb_wa}, 32'd0);
    chk("reset_wb_data", wb_data, 32'd0);
    chk("reset_wb_count", wb_count, 32'd0);
    chk("reset_ovf", {31'b0, lsu_overflow}, 32'd0);
    chk("reset_alu_ready", {31'b0, alu_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // ALU only
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'h1234;
    cycle();
    chk("t1_en", {31'b0, wb_en}, 32'd1);
    chk("t1_wa", {27'b0, wb_wa}, 32'd5);
    chk("t1_data", wb_data, 32'h1234);
    chk("t1_count", wb_count, 32'd1);
    idle();
    cycle();

    // Load extension
    apply_reset();
    lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 32'h0080_0000; lsu_funct3 = 3'b000; lsu_addr_lo = 2'd2;
    cycle();
    idle();
    cycle();
    chk("t2_lb_data", wb_data, 32'hFFFF_FF80);
    chk("t2_lb_wa", {27'b0, wb_wa}, 32'd7);
    lsu_valid = 1; lsu_rd = 5'd8; lsu_data = 32'h8000_0000; lsu_funct3 = 3'b101; lsu_addr_lo = 2'd2;
    cycle();
    idle();
    cycle();
    chk("t2_lhu_data", wb_data, 32'h0000_8000);
    chk("t2_count", wb_count, 32'd2);

    // Contention: ALU held, one load return
    apply_reset();
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'hAA;
    lsu_valid = 1; lsu_rd = 5'd9; lsu_data = 32'h55; lsu_funct3 = 3'b010; lsu_addr_lo = 2'd0;
    cycle();
    chk("t3_first_wa", {27'b0, wb_wa}, 32'd3);
    lsu_valid = 0;
    #1 chk("t3_alu_blocked", {31'b0, alu_ready}, 32'd0);
    cycle();
    chk("t3_lsu_wa", {27'b0, wb_wa}, 32'd9);
    chk("t3_lsu_data", wb_data, 32'h55);
    cycle();
    chk("t3_alu_wa", {27'b0, wb_wa}, 32'd3);
    chk("t3_alu_data", wb_data, 32'hAA);
    chk("t3_count", wb_count, 32'd3);
    idle();

    // rd == 0
    apply_reset();
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hDEAD;
    cycle();
    chk("t5_en", {31'b0, wb_en}, 32'd0);
    chk("t5_data", wb_data, 32'd0);
    chk("t5_count", wb_count, 32'd1);
    idle();

    // Burst then async reset
    for (int i = 0; i < 10; i++) begin
      rand_inputs();
      cycle();
    end
    mid_reset();

`ifdef WB_FORWARD_EN
    alu_valid = 1; alu_rd = 5'd12; alu_data = 32'h77;
    cycle();
    idle();
    fwd_rs_a = 5'd12;
    #1;
    chk("t6_fwd_hit", {31'b0, fwd_hit_a}, 32'd1);
    chk("t6_fwd_data", fwd_data_a, 32'h77);
    cycle();
`endif

    // Random traffic with occasional async resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        mid_reset();
      end else begin
        rand_inputs();
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
